// File: rtl/counters_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counters_pkg
// Description : Shared helpers and encodings for the counters_and_timers library.
// Revision    : 1.0 - initial release
// ============================================================================
package counters_pkg;

  localparam logic MODE_FREE    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Bits needed to hold the value itself; 0 for value 0, callers clamp to 1.
  function automatic int clogb2(input int value);
    int v;
    int bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

  function automatic int width_of(input int max_value);
    int w;
    w = clogb2(max_value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : counters_pkg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Emits one tick per PRESCALE enabled clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler
  import counters_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic aclr,
  input  logic enable,
  input  logic clr,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      logic unused_inputs;
      assign unused_inputs = ^{clk, aclr, clr};
      assign tick          = enable;
    end else begin : g_count
      localparam int            PW   = width_of(PRESCALE - 1);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] cnt_q;
      logic [PW-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (enable) begin
          cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
        end
      end

      always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign tick = enable & (cnt_q == LAST);
    end
  endgenerate

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/counter_prog_mod_updown.sv
`default_nettype none
// ============================================================================
// Module      : counter_prog_mod_updown
// Description : Programmable-modulus up/down counter/timer with prescaler,
//               one-shot mode, synchronous load and double-buffered top.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_prog_mod_updown
  import counters_pkg::*;
#(
  parameter  int MMAX     = 1000,
  parameter  int PRESCALE = 1,
  localparam int N        = width_of(MMAX - 1)
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic         enable,
  input  logic         up_dn,
  input  logic         mode,
  input  logic         mod_wr,
  input  logic [N-1:0] mod_data,
  input  logic         sload,
  input  logic [N-1:0] load_data,
  input  logic         start,
  output logic [N-1:0] Q,
  output logic         tc,
  output logic         done
);

  localparam logic [N-1:0] TOP_RST = N'(MMAX - 1);

  function automatic logic [N-1:0] clamp_top(input logic [N-1:0] v);
    return (v > TOP_RST) ? TOP_RST : v;
  endfunction

  logic [N-1:0] q_q,      q_d;
  logic [N-1:0] top_q,    top_d;
  logic [N-1:0] shadow_q, shadow_d;
  logic         pend_q,   pend_d;
  logic         done_q,   done_d;

  logic         tick;
  logic         terminal;
  logic         tc_w;
  logic [N-1:0] top_eff;
  logic [N-1:0] wrap_top;
  logic [N-1:0] mod_clamped;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .aclr   (aclr),
    .enable (enable),
    .clr    (sload | start),
    .tick   (tick)
  );

  assign top_eff     = pend_q ? shadow_q : top_q;
  assign mod_clamped = clamp_top(mod_data);
  // A write landing on the wrap cycle takes effect at that very wrap.
  assign wrap_top    = mod_wr ? mod_clamped : top_eff;
  assign terminal    = up_dn ? (q_q == top_q) : (q_q == '0);
  assign tc_w        = tick & terminal & ~done_q;

  always_comb begin
    q_d      = q_q;
    top_d    = top_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    done_d   = done_q;

    if (mod_wr) begin
      shadow_d = mod_clamped;
      pend_d   = 1'b1;
    end

    if (sload) begin
      q_d    = (load_data > top_eff) ? top_eff : load_data;
      top_d  = top_eff;
      pend_d = mod_wr;
      done_d = 1'b0;
    end else if (start) begin
      q_d    = up_dn ? '0 : top_eff;
      top_d  = top_eff;
      pend_d = mod_wr;
      done_d = 1'b0;
    end else if (tick && !done_q) begin
      if (terminal) begin
        top_d  = wrap_top;
        pend_d = 1'b0;
        if (mode == MODE_ONESHOT) begin
          done_d = 1'b1;
        end else begin
          q_d = up_dn ? '0 : wrap_top;
        end
      end else begin
        q_d = up_dn ? q_q + N'(1) : q_q - N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      q_q      <= '0;
      top_q    <= TOP_RST;
      shadow_q <= TOP_RST;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      top_q    <= top_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
    end
  end

  assign Q    = q_q;
  assign tc   = tc_w;
  assign done = done_q;

endmodule : counter_prog_mod_updown
`default_nettype wire

// File: tb/tb_counter_prog_mod_updown.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_prog_mod_updown
// Description : Directed self-checking bench; MMAX=10 with PRESCALE 1 and 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_prog_mod_updown;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         aclr;
  logic         enable, up_dn, mode, mod_wr, sload, start;
  logic [N-1:0] mod_data, load_data;
  logic [N-1:0] q1, q2;
  logic         tc1, tc2, done1, done2;

  int tests = 0;
  int fails = 0;

  int e3q [9] = '{7, 8, 9, 0, 1, 2, 3, 4, 0};
  int e3t [9] = '{0, 0, 1, 0, 0, 0, 0, 1, 0};

  always #5 clk = ~clk;

  counter_prog_mod_updown #(.MMAX(10), .PRESCALE(1)) dut (
    .clk(clk), .aclr(aclr), .enable(enable), .up_dn(up_dn), .mode(mode),
    .mod_wr(mod_wr), .mod_data(mod_data), .sload(sload), .load_data(load_data),
    .start(start), .Q(q1), .tc(tc1), .done(done1)
  );

  counter_prog_mod_updown #(.MMAX(10), .PRESCALE(4)) dut_p (
    .clk(clk), .aclr(aclr), .enable(enable), .up_dn(up_dn), .mode(mode),
    .mod_wr(mod_wr), .mod_data(mod_data), .sload(sload), .load_data(load_data),
    .start(start), .Q(q2), .tc(tc2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    aclr = 1'b0; enable = 1'b0; up_dn = 1'b1; mode = 1'b0; mod_wr = 1'b0;
    sload = 1'b0; start = 1'b0; mod_data = '0; load_data = '0;
    #8;
    chk("reset_q", q1, 0);
    chk("reset_done", done1, 0);
    chk("reset_tc", tc1, 0);
    chk("reset_q2", q2, 0);
    chk("reset_done2", done2, 0);
    aclr = 1'b1;
    step();

    // free-run up through the reset modulus
    enable = 1'b1; up_dn = 1'b1; #1;
    for (int i = 0; i < 12; i++) begin
      chk("up_q", q1, i % 10);
      chk("up_tc", tc1, (i % 10) == 9);
      step();
    end

    // free-run down
    enable = 1'b0; sload = 1'b1; load_data = 4'd0;
    step();
    sload = 1'b0; up_dn = 1'b0; enable = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("dn_q", q1, (10 - i) % 10);
      chk("dn_tc", tc1, i == 0);
      step();
    end

    // shadow top written mid-count takes effect after the wrap
    up_dn = 1'b1; mod_wr = 1'b1; mod_data = 4'd4; #1;
    chk("mw_q6", q1, 6);
    step();
    mod_wr = 1'b0; #1;
    for (int i = 0; i < 9; i++) begin
      chk("mw_q", q1, e3q[i]);
      chk("mw_tc", tc1, e3t[i]);
      step();
    end

    // clamp on mod_wr and on sload
    enable = 1'b0; mod_wr = 1'b1; mod_data = 4'd15;
    step();
    mod_wr = 1'b0; sload = 1'b1; load_data = 4'd15;
    step();
    sload = 1'b0; #1;
    chk("clamp_q", q1, 9);
    enable = 1'b1; #1;
    chk("clamp_tc", tc1, 1);
    sload = 1'b1; load_data = 4'd3;
    step();
    chk("load_wins", q1, 3);

    // mod_wr coinciding with the wrap is committed at that wrap
    load_data = 4'd9;
    step();
    sload = 1'b0; mod_wr = 1'b1; mod_data = 4'd6; #1;
    chk("wrapwr_tc", tc1, 1);
    step();
    mod_wr = 1'b0; #1;
    chk("wrapwr_q0", q1, 0);
    step(6);
    chk("wrapwr_q6", q1, 6);
    chk("wrapwr_tc6", tc1, 1);
    step();
    chk("wrapwr_wrap", q1, 0);

    // modulus 1
    enable = 1'b0; mod_wr = 1'b1; mod_data = 4'd0;
    step();
    mod_wr = 1'b0; sload = 1'b1; load_data = 4'd5;
    step();
    sload = 1'b0; #1;
    chk("m1_q", q1, 0);
    enable = 1'b1; #1;
    chk("m1_tc", tc1, 1);
    step();
    chk("m1_q_hold", q1, 0);
    chk("m1_tc_again", tc1, 1);

    // one-shot up, top=3
    enable = 1'b0; mod_wr = 1'b1; mod_data = 4'd3;
    step();
    mod_wr = 1'b0; mode = 1'b1; up_dn = 1'b1; start = 1'b1;
    step();
    start = 1'b0; #1;
    chk("os_start_q", q1, 0);
    chk("os_start_done", done1, 0);
    enable = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("os_q", q1, i);
      chk("os_tc", tc1, i == 3);
      chk("os_done", done1, 0);
      step();
    end
    chk("os_end_q", q1, 3);
    chk("os_end_done", done1, 1);
    chk("os_end_tc", tc1, 0);
    step(2);
    chk("os_hold_q", q1, 3);
    chk("os_hold_done", done1, 1);
    chk("os_hold_tc", tc1, 0);
    start = 1'b1;
    step();
    start = 1'b0; #1;
    chk("os_rearm_q", q1, 0);
    chk("os_rearm_done", done1, 0);
    step(4);
    chk("os_again_q", q1, 3);
    chk("os_again_done", done1, 1);

    // asynchronous clear acts between clock edges
    aclr = 1'b0; #2;
    chk("aclr_q", q1, 0);
    chk("aclr_done", done1, 0);
    chk("aclr_q2", q2, 0);
    aclr = 1'b1;
    step();

    // prescaler of 4 on the second instance, top=2
    mode = 1'b0; enable = 1'b0; mod_wr = 1'b1; mod_data = 4'd2;
    step();
    mod_wr = 1'b0; sload = 1'b1; load_data = 4'd0;
    step();
    sload = 1'b0; enable = 1'b1; #1;
    step(3);
    chk("ps_q_pre", q2, 0);
    step();
    chk("ps_q_tick1", q2, 1);
    enable = 1'b0;
    step(3);
    chk("ps_freeze", q2, 1);
    enable = 1'b1;
    step(3);
    chk("ps_resume_pre", q2, 1);
    step();
    chk("ps_q_tick2", q2, 2);
    chk("ps_tc_notick", tc2, 0);
    step(3);
    chk("ps_tc", tc2, 1);
    step();
    chk("ps_wrap", q2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_counter_prog_mod_updown
`default_nettype wire
